calendar_time_controller: RTL
=============================

Name: calendar_time_controller

Overview:
- Synchronous controller for the year/month/day/hour/minute/second calendar datapath.
- Replaces ripple-clocked counter chaining: one clk, a seconds prescaler, and a single-cycle enable cascade across all six fields.
- Adds a user set-time FSM. Button pulses select a field and increment it; the clock is frozen while setting.
- Sits between the board button debouncers and the display/monitor logic.

Parameters:
- TICKS_PER_SEC, 50, clk cycles per second; must be >= 2.
- DAY_MAX, 30, last day of every month; days run 1..DAY_MAX.
- MONTH_MAX, 12, last month; months run 1..MONTH_MAX.
- YEAR_MAX, 63, last year before wrap; years run 0..YEAR_MAX.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- mode_btn  in  1  single-cycle pulse; advance set-mode field
- inc_btn  in  1  single-cycle pulse; increment selected field
- year  out  6  0..YEAR_MAX
- month  out  4  1..MONTH_MAX
- day  out  5  1..DAY_MAX
- hour  out  5  0..23
- minute  out  6  0..59
- second  out  6  0..59
- sel  out  3  0=RUN, 1=year, 2=month, 3=day, 4=hour, 5=minute, 6=second
- sec_tick  out  1  one-cycle pulse when second advances in RUN

Behaviour:
- Reset (rst=1 at posedge clk):
  - year=0, month=1, day=1, hour=0, minute=0, second=0.
  - sel=0 (RUN), prescaler=0, sec_tick=0.
  - Reset overrides all other inputs and applies in any state, including mid-set.
- All outputs are registered. Button effects are visible the cycle after the sampling edge.
- FSM states: RUN, SET_YEAR, SET_MONTH, SET_DAY, SET_HOUR, SET_MIN, SET_SEC. sel encodes the state.
- Transitions: mode_btn moves RUN->SET_YEAR->SET_MONTH->SET_DAY->SET_HOUR->SET_MIN->SET_SEC->RUN. Otherwise the state holds.
- RUN operation:
  - Prescaler counts 0..TICKS_PER_SEC-1, then wraps.
  - When prescaler == TICKS_PER_SEC-1, second increments and sec_tick=1 for exactly that cycle.
- Cascade (all within the same clock edge, no ripple):
  - second 59->0 carries to minute.
  - minute 59->0 carries to hour.
  - hour 23->0 carries to day.
  - day DAY_MAX->1 carries to month.
  - month MONTH_MAX->1 carries to year.
  - year YEAR_MAX->0; no carry out.
- SET_x states:
  - Prescaler is held at 0 and sec_tick=0; all fields are frozen except by inc_btn.
  - inc_btn increments only the selected field and wraps to that field's minimum.
  - No carry propagates to neighbouring fields.
- Leaving SET_SEC for RUN: prescaler restarts from 0, so the first sec_tick occurs TICKS_PER_SEC cycles after the transition edge.
- inc_btn in RUN is ignored.
- mode_btn and inc_btn high in the same cycle: mode_btn wins and inc_btn is dropped.
- Day is not clamped on month change, because every month has DAY_MAX days.
- Out-of-range values are unreachable; no clamping logic is required.

Decomposition:
- Shared package calendar_pkg holds:
  - state/sel encoding constants (SEL_RUN..SEL_SEC);
  - field range constants (SEC_MAX=59, MIN_MAX=59, HOUR_MAX=23);
  - field widths.
- Sub-module wrap_field: a parameterised counter with MIN, MAX and WIDTH.
  - Inputs: clk, rst, en.
  - Outputs: value, and carry = en && value==MAX.
  - Reset loads MIN.
  - Instantiate six times. The controller drives each en from (RUN cascade carry) OR (set-mode inc for that field).

Test Plan (TICKS_PER_SEC=4, DAY_MAX=30, MONTH_MAX=12, YEAR_MAX=63):
1. Reset, then 8 idle cycles -> after reset: outputs 0/1/1/0/0/0, sel=0. sec_tick pulses on cycles 4 and 8; second=2 after cycle 8.
2. Set fields to year 0, month 1, day 1, 23:59:59, return to RUN -> 4 cycles later a single edge gives day=2, hour=0, minute=0, second=0, and exactly one sec_tick.
3. Set 63/12/30 23:59:59, run one second -> year=0, month=1, day=1, 00:00:00 in the same cycle.
4. From RUN: mode_btn gives sel=1; three inc_btn pulses give year=3. Hold 20 cycles with no buttons -> all fields unchanged, sec_tick never asserted. Six more mode_btn pulses give sel=0, then ticking resumes after 4 cycles.
5. mode_btn and inc_btn together in SET_MONTH with month=5 -> sel=3, month stays 5. inc_btn in RUN -> no field change.
6. rst asserted for one cycle while sel=4 with hour=7 -> next cycle: sel=0, hour=0, all fields at reset values, prescaler restarts at 0.

Source files
------------

// File: rtl/calendar_pkg.sv
// rtl/calendar_pkg.sv - shared encodings, field ranges and widths for the calendar controller
//
// Purpose: single home for the set-mode state / sel encoding, the fixed
//          time-of-day field ranges and the output field widths, so the
//          top and its field counters agree on every constant.
// Ports:   none (package).
package calendar_pkg;

    // sel output encoding; the FSM state value is driven straight onto sel
    localparam logic [2:0] SEL_RUN   = 3'd0;
    localparam logic [2:0] SEL_YEAR  = 3'd1;
    localparam logic [2:0] SEL_MONTH = 3'd2;
    localparam logic [2:0] SEL_DAY   = 3'd3;
    localparam logic [2:0] SEL_HOUR  = 3'd4;
    localparam logic [2:0] SEL_MIN   = 3'd5;
    localparam logic [2:0] SEL_SEC   = 3'd6;

    typedef enum logic [2:0] {
        ST_RUN       = SEL_RUN,
        ST_SET_YEAR  = SEL_YEAR,
        ST_SET_MONTH = SEL_MONTH,
        ST_SET_DAY   = SEL_DAY,
        ST_SET_HOUR  = SEL_HOUR,
        ST_SET_MIN   = SEL_MIN,
        ST_SET_SEC   = SEL_SEC
    } state_t;

    // time-of-day ranges are fixed; calendar ranges are top-level parameters
    localparam int SEC_MAX  = 59;
    localparam int MIN_MAX  = 59;
    localparam int HOUR_MAX = 23;

    localparam int YEAR_W  = 6;
    localparam int MONTH_W = 4;
    localparam int DAY_W   = 5;
    localparam int HOUR_W  = 5;
    localparam int MIN_W   = 6;
    localparam int SEC_W   = 6;
    localparam int SEL_W   = 3;

    // mode_btn walks the fields in display order and then back to RUN
    function automatic state_t next_mode(input state_t s);
        state_t n;
        case (s)
            ST_RUN:       n = ST_SET_YEAR;
            ST_SET_YEAR:  n = ST_SET_MONTH;
            ST_SET_MONTH: n = ST_SET_DAY;
            ST_SET_DAY:   n = ST_SET_HOUR;
            ST_SET_HOUR:  n = ST_SET_MIN;
            ST_SET_MIN:   n = ST_SET_SEC;
            ST_SET_SEC:   n = ST_RUN;
            default:      n = ST_RUN;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/wrap_field.sv
// rtl/wrap_field.sv - wrapping MIN..MAX counter with same-cycle carry
//
// Purpose: one calendar field. Counts up by one on each enabled cycle and
//          wraps from MAX back to MIN. carry is combinational so the next
//          field up can advance on the very same clock edge.
// Ports:
//   clk    in   system clock
//   rst    in   synchronous active-high reset, loads MIN
//   en     in   advance this field on the next edge
//   value  out  current field value (registered)
//   carry  out  en && value == MAX, i.e. this edge wraps the field
module wrap_field #(
    parameter int WIDTH = 6,
    parameter int MIN   = 0,
    parameter int MAX   = 59
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] value,
    output logic             carry
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] value_q;
    logic [WIDTH-1:0] value_d;
    logic             at_max;

    assign at_max = (value_q == MAX_V);

    always_comb begin
        value_d = value_q;
        if (en) begin
            value_d = at_max ? MIN_V : value_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= MIN_V;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;
    assign carry = en && at_max;

endmodule

// File: rtl/calendar_time_controller.sv
// rtl/calendar_time_controller.sv - single-clock calendar with prescaler, carry cascade and set-time FSM
//
// Purpose: keeps year/month/day/hour/minute/second on one clock. A seconds
//          prescaler produces a one-cycle tick in RUN; the tick ripples
//          through six wrap_field counters combinationally so every field
//          that rolls over does so on the same edge. mode_btn walks a
//          set-time FSM that freezes the clock and lets inc_btn bump the
//          selected field alone, with no carry into its neighbours.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset, overrides everything
//   mode_btn  in   one-cycle pulse, advance to the next set field / RUN
//   inc_btn   in   one-cycle pulse, increment the selected field
//   year      out  0..YEAR_MAX
//   month     out  1..MONTH_MAX
//   day       out  1..DAY_MAX
//   hour      out  0..23
//   minute    out  0..59
//   second    out  0..59
//   sel       out  0=RUN, 1..6 = field being set (year..second)
//   sec_tick  out  one-cycle pulse, coincident with second advancing in RUN
module calendar_time_controller
    import calendar_pkg::*;
#(
    parameter int TICKS_PER_SEC = 50,   // must be >= 2
    parameter int DAY_MAX       = 30,
    parameter int MONTH_MAX     = 12,
    parameter int YEAR_MAX      = 63
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode_btn,
    input  logic               inc_btn,
    output logic [YEAR_W-1:0]  year,
    output logic [MONTH_W-1:0] month,
    output logic [DAY_W-1:0]   day,
    output logic [HOUR_W-1:0]  hour,
    output logic [MIN_W-1:0]   minute,
    output logic [SEC_W-1:0]   second,
    output logic [SEL_W-1:0]   sel,
    output logic               sec_tick
);

    localparam int PRESC_W = (TICKS_PER_SEC > 2) ? $clog2(TICKS_PER_SEC) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICKS_PER_SEC - 1);

    state_t             state_q;
    state_t             state_d;
    logic [PRESC_W-1:0] presc_q;
    logic [PRESC_W-1:0] presc_d;
    logic               sec_tick_q;
    logic               sec_tick_d;

    logic run;
    logic tick;
    logic inc_eff;

    logic en_year, en_month, en_day, en_hour, en_min, en_sec;
    logic c_month, c_day, c_hour, c_min, c_sec;
    logic year_carry_unused;

    assign run  = (state_q == ST_RUN);
    assign tick = run && (presc_q == PRESC_LAST);
    // a simultaneous mode_btn consumes the press; inc_btn is dropped
    assign inc_eff = inc_btn && !mode_btn;

    always_comb begin
        state_d    = state_q;
        presc_d    = presc_q;
        sec_tick_d = 1'b0;

        if (mode_btn) begin
            state_d = next_mode(state_q);
        end

        // Outside RUN the prescaler sits at 0, so returning to RUN always
        // gives a full second before the first tick.
        if (!run || tick) begin
            presc_d = '0;
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end

        sec_tick_d = tick;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            presc_q    <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    // Carries are only honoured in RUN: a set-mode wrap must not spill
    // into the next field.
    assign en_sec   = tick || (inc_eff && state_q == ST_SET_SEC);
    assign en_min   = (run && c_sec)   || (inc_eff && state_q == ST_SET_MIN);
    assign en_hour  = (run && c_min)   || (inc_eff && state_q == ST_SET_HOUR);
    assign en_day   = (run && c_hour)  || (inc_eff && state_q == ST_SET_DAY);
    assign en_month = (run && c_day)   || (inc_eff && state_q == ST_SET_MONTH);
    assign en_year  = (run && c_month) || (inc_eff && state_q == ST_SET_YEAR);

    wrap_field #(.WIDTH(SEC_W), .MIN(0), .MAX(SEC_MAX)) u_sec (
        .clk   (clk),
        .rst   (rst),
        .en    (en_sec),
        .value (second),
        .carry (c_sec)
    );

    wrap_field #(.WIDTH(MIN_W), .MIN(0), .MAX(MIN_MAX)) u_min (
        .clk   (clk),
        .rst   (rst),
        .en    (en_min),
        .value (minute),
        .carry (c_min)
    );

    wrap_field #(.WIDTH(HOUR_W), .MIN(0), .MAX(HOUR_MAX)) u_hour (
        .clk   (clk),
        .rst   (rst),
        .en    (en_hour),
        .value (hour),
        .carry (c_hour)
    );

    wrap_field #(.WIDTH(DAY_W), .MIN(1), .MAX(DAY_MAX)) u_day (
        .clk   (clk),
        .rst   (rst),
        .en    (en_day),
        .value (day),
        .carry (c_day)
    );

    wrap_field #(.WIDTH(MONTH_W), .MIN(1), .MAX(MONTH_MAX)) u_month (
        .clk   (clk),
        .rst   (rst),
        .en    (en_month),
        .value (month),
        .carry (c_month)
    );

    // year wraps to 0 with nowhere further to carry
    wrap_field #(.WIDTH(YEAR_W), .MIN(0), .MAX(YEAR_MAX)) u_year (
        .clk   (clk),
        .rst   (rst),
        .en    (en_year),
        .value (year),
        .carry (year_carry_unused)
    );

    assign sel      = state_q;
    assign sec_tick = sec_tick_q;

endmodule
